seq_shift_mul: RTL and testbench
================================

# seq_shift_mul

Iterative shift-and-add multiplier: the parametrised successor of the per-bit `shift_block` partial-product cells. It accepts two WIDTH-bit operands over a valid/ready handshake and retires STEP multiplier bits per clock, reusing one adder instead of WIDTH parallel cells. It produces a 2*WIDTH-bit product in signed or unsigned mode. It sits beside the execute-stage ALU as the multi-cycle M-extension multiply unit.

## Interface
- WIDTH, 32, operand width; even, ≥4.
- STEP, 1, multiplier bits retired per cycle; one of 1, 2, 4; WIDTH % STEP == 0.
- CLK  input  1  clock, rising edge.
- RST  input  1  reset; one clock, asynchronous, active-high.
- in_valid  input  1  operands valid.
- in_ready  output  1  unit can accept operands.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
- abort  input  1  discard the operation in flight.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer takes product.
- res  output  2*WIDTH  product.
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch |a| and |b| (magnitudes as unsigned WIDTH bits; -2^(WIDTH-1) maps to 2^(WIDTH-1)).
  - Latch neg = in_signed & (a[MSB] ^ b[MSB]).
  - Clear accumulator and step counter, then go to CALC.
- CALC, each cycle:
  - acc += (|a| * b_sh[STEP-1:0]) << (cnt*STEP).
  - b_sh >>= STEP; cnt++.
  - After N = WIDTH/STEP cycles, go to SIGN.
- SIGN: if neg, acc = ~acc + 1 (2*WIDTH bits, wraps); go to DONE.
- DONE:
  - out_valid=1; res = acc.
  - On out_ready, go to IDLE.
- Arithmetic: accumulator is 2*WIDTH bits and never overflows before SIGN.
- Zero operand: no early-out; latency is fixed.
- abort:
  - In CALC or SIGN: go to IDLE next edge; no out_valid.
  - In DONE: drops the result; go to IDLE.
  - In IDLE: ignored; in_valid is still honoured that cycle.
- Inputs are ignored outside IDLE; in_a, in_b and in_signed may change freely once accepted.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, busy=0, res=0.
  - State IDLE; acc, cnt and operand registers 0.
- Latency: operands accepted at edge k → out_valid high after edge k+N+1 (WIDTH=32, STEP=1: k+33).
- Throughput: one product per N+3 cycles with out_ready held high. in_ready returns the cycle after the output handshake.
- res is registered and stable for the whole time out_valid is high. out_valid stays high until out_ready; backpressure is unlimited.
- RST mid-operation: immediate return to reset values; no out_valid for the interrupted operation.
- abort and out_ready together in DONE: abort wins; the result is not considered delivered.

## Structure
- Package mul_pkg holds:
  - state enum (IDLE, CALC, SIGN, DONE);
  - STEP legality check;
  - helper function for magnitude extraction.
- One sub-module, pp_step (combinational): WIDTH-bit multiplicand × STEP-bit digit → WIDTH+STEP-bit partial product. It is the generalised successor of the per-bit cell. seq_shift_mul instantiates it once.
- Elaboration-time assertion on WIDTH % STEP.

## Test plan
- WIDTH=4, STEP=1, unsigned, in_a=8, in_b=9 → res=8'd72; out_valid exactly 5 cycles after accept.
- WIDTH=8, signed, in_a=-3 (8'hFD), in_b=5 → res=16'hFFF1. Same operands unsigned → 16'h04F1.
- WIDTH=8, signed, in_a=in_b=8'h80 → res=16'h4000. in_a=8'h80, in_b=1 → 16'hFF80.
- Backpressure:
  - hold out_ready=0 for 3 cycles after out_valid → res and out_valid stable;
  - in_ready stays 0 while in_valid is presented and new operands are not taken;
  - release → handshake, in_ready=1 next cycle.
- Reset and abort:
  - assert RST asynchronously at CALC cycle 3 → outputs at reset values immediately, no out_valid;
  - abort in CALC → IDLE next edge, no out_valid;
  - new op 7*6 → res=42.
- WIDTH=32, STEP=4: random 1000 signed/unsigned pairs vs reference model; out_valid 9 cycles after accept.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative shift-and-add multiplier.
// Holds the FSM state encoding, the configuration legality check and magnitude extraction.
package mul_pkg;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_e;

  localparam int MAX_W = 64;

  function automatic bit step_legal(input int width, input int step);
    return (step == 1 || step == 2 || step == 4) && (width % step == 0) &&
           (width >= 4) && (width % 2 == 0) && (width <= MAX_W);
  endfunction

  // Low bits of the result are |v|; the most negative value maps onto its own unsigned pattern.
  function automatic logic [MAX_W-1:0] magnitude(input logic [MAX_W-1:0] v, input logic is_neg);
    return is_neg ? (~v + MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/pp_step.sv
// Combinational partial product: WIDTH-bit multiplicand times a STEP-bit multiplier digit.
module pp_step #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0]      mcand_i,
  input  logic [STEP-1:0]       digit_i,
  output logic [WIDTH+STEP-1:0] pp_o
);

  logic [WIDTH+STEP-1:0] term [STEP];

  for (genvar gi = 0; gi < STEP; gi++) begin : g_term
    assign term[gi] = (WIDTH+STEP)'(mcand_i & {WIDTH{digit_i[gi]}}) << gi;
  end

  always_comb begin
    pp_o = '0;
    for (int i = 0; i < STEP; i++) begin
      pp_o = pp_o + term[i];
    end
  end

endmodule

// File: rtl/seq_shift_mul.sv
// Multi-cycle signed/unsigned multiplier retiring STEP multiplier bits per clock.
// Magnitudes are multiplied unsigned; the sign is applied in one extra SIGN cycle.
module seq_shift_mul
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res,
  output logic               busy
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N + 1);

  if (!step_legal(WIDTH, STEP)) begin : g_bad_cfg
    $error("seq_shift_mul: illegal WIDTH/STEP combination");
  end

  state_e               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH+STEP-1:0] pp;
  logic [2*WIDTH-1:0]   pp_shifted;

  pp_step #(.WIDTH(WIDTH), .STEP(STEP)) u_pp (
    .mcand_i (a_q),
    .digit_i (b_q[STEP-1:0]),
    .pp_o    (pp)
  );

  assign pp_shifted = (2*WIDTH)'(pp) << (int'(cnt_q) * STEP);
  assign acc_d      = acc_q + pp_shifted;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= WIDTH'(magnitude(MAX_W'(in_a), in_signed & in_a[WIDTH-1]));
            b_q     <= WIDTH'(magnitude(MAX_W'(in_b), in_signed & in_b[WIDTH-1]));
            neg_q   <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            b_q   <= b_q >> STEP;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) state_q <= SIGN;
          end
        end
        SIGN: begin
          if (abort) begin
            state_q <= IDLE;
          end else begin
            if (neg_q) acc_q <= ~acc_q + (2*WIDTH)'(1);
            state_q <= DONE;
          end
        end
        DONE: begin
          // abort alongside out_ready still discards the product
          if (abort || out_ready) state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res       = acc_q;

endmodule

// File: tb/tb_seq_shift_mul.sv
// Scoreboard bench for seq_shift_mul: three configurations (4/1, 8/1, 32/4) checked
// against an arithmetic reference; monitors pop expected products on each output handshake.
module tb_seq_shift_mul;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  logic       v4, r4, s4, ab4, ov4, or4, bz4;
  logic [3:0] a4, b4;
  logic [7:0] res4;
  logic        v8, r8, s8, ab8, ov8, or8, bz8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;
  logic        v32, r32, s32, ab32, ov32, or32, bz32;
  logic [31:0] a32, b32;
  logic [63:0] res32;

  seq_shift_mul #(.WIDTH(4), .STEP(1)) dut4 (
    .CLK(CLK), .RST(RST), .in_valid(v4), .in_ready(r4), .in_a(a4), .in_b(b4),
    .in_signed(s4), .abort(ab4), .out_valid(ov4), .out_ready(or4), .res(res4), .busy(bz4));
  seq_shift_mul #(.WIDTH(8), .STEP(1)) dut8 (
    .CLK(CLK), .RST(RST), .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8),
    .in_signed(s8), .abort(ab8), .out_valid(ov8), .out_ready(or8), .res(res8), .busy(bz8));
  seq_shift_mul #(.WIDTH(32), .STEP(4)) dut32 (
    .CLK(CLK), .RST(RST), .in_valid(v32), .in_ready(r32), .in_a(a32), .in_b(b32),
    .in_signed(s32), .abort(ab32), .out_valid(ov32), .out_ready(or32), .res(res32), .busy(bz32));

  logic [63:0] q4[$];
  logic [63:0] q8[$];
  logic [63:0] q32[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference product: interpret operands as w-bit integers, multiply exactly, keep 2w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input bit s, input int w);
    longint sa, sb;
    logic [63:0] p, mask;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    p    = 64'(sa * sb);
    mask = (64'd1 << (2 * w)) - 64'd1;
    return p & mask;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic s);
    case (sel)
      4:       begin v4 = v;  a4 = a[3:0]; b4 = b[3:0]; s4 = s;  end
      8:       begin v8 = v;  a8 = a[7:0]; b8 = b[7:0]; s8 = s;  end
      default: begin v32 = v; a32 = a;     b32 = b;     s32 = s; end
    endcase
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 4) ? r4 : (sel == 8) ? r8 : r32;
  endfunction

  function automatic logic ovld(input int sel);
    return (sel == 4) ? ov4 : (sel == 8) ? ov8 : ov32;
  endfunction

  // Presents operands, returns at edge+1 after the accepting edge with in_valid dropped.
  task automatic accept(input int sel, input logic [31:0] a, input logic [31:0] b, input logic s);
    int n = 0;
    @(posedge CLK); #1;
    drive(sel, 1'b1, a, b, s);
    @(negedge CLK);
    while (!rdy(sel) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!rdy(sel)) timeout($sformatf("accept%0d", sel));
    @(posedge CLK); #1;
    drive(sel, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_out(input int sel, input int exp_lat);
    int j = 0;
    @(negedge CLK);
    while (!ovld(sel) && j < 100) begin
      @(negedge CLK);
      j++;
    end
    if (!ovld(sel)) timeout($sformatf("out_valid%0d", sel));
    else check($sformatf("latency%0d", sel), 64'(j), 64'(exp_lat));
  endtask

  task automatic op(input int sel, input logic [31:0] a, input logic [31:0] b, input logic s,
                    input logic [63:0] exp, input int lat);
    case (sel)
      4:       q4.push_back(exp);
      8:       q8.push_back(exp);
      default: q32.push_back(exp);
    endcase
    accept(sel, a, b, s);
    wait_out(sel, lat);
    @(posedge CLK); #1;
  endtask

  task automatic quiet(input int sel, input int cycles, input string name);
    logic seen = 1'b0;
    repeat (cycles) begin
      @(negedge CLK);
      if (ovld(sel)) seen = 1'b1;
    end
    check(name, 64'(seen), 64'(0));
  endtask

  always @(negedge CLK) begin
    if (!RST && ov4 && or4 && !ab4) begin
      $display("[TB] d4 product res=%h", res4);
      if (q4.size() == 0) begin tests++; fails++; $display("FAIL mon4: got res %h, expected no output", res4); end
      else check("mon4_res", 64'(res4), q4.pop_front());
    end
    if (!RST && ov8 && or8 && !ab8) begin
      $display("[TB] d8 product res=%h", res8);
      if (q8.size() == 0) begin tests++; fails++; $display("FAIL mon8: got res %h, expected no output", res8); end
      else check("mon8_res", 64'(res8), q8.pop_front());
    end
    if (!RST && ov32 && or32 && !ab32) begin
      $display("[TB] d32 product res=%h", res32);
      if (q32.size() == 0) begin tests++; fails++; $display("FAIL mon32: got res %h, expected no output", res32); end
      else check("mon32_res", res32, q32.pop_front());
    end
  end

  initial begin
    logic [15:0] hold;
    RST = 1'b1;
    drive(4, 1'b0, 0, 0, 1'b0);
    drive(8, 1'b0, 0, 0, 1'b0);
    drive(32, 1'b0, 0, 0, 1'b0);
    ab4 = 1'b0; ab8 = 1'b0; ab32 = 1'b0;
    or4 = 1'b1; or8 = 1'b1; or32 = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_in_ready", 64'({r4, r8, r32}), 64'(3'b111));
    check("rst_out_valid", 64'({ov4, ov8, ov32}), 64'(0));
    check("rst_busy", 64'({bz4, bz8, bz32}), 64'(0));
    check("rst_res", res32 | 64'(res8) | 64'(res4), 64'(0));
    RST = 1'b0;

    op(4, 32'd8, 32'd9, 1'b0, 64'd72, 5);
    op(8, 32'hFD, 32'd5, 1'b1, 64'hFFF1, 9);
    op(8, 32'hFD, 32'd5, 1'b0, 64'h04F1, 9);
    op(8, 32'h80, 32'h80, 1'b1, 64'h4000, 9);
    op(8, 32'h80, 32'h01, 1'b1, 64'hFF80, 9);

    // Backpressure: product held while consumer stalls, new operands refused.
    or8 = 1'b0;
    q8.push_back(64'h03A8);
    accept(8, 32'h12, 32'h34, 1'b0);
    wait_out(8, 9);
    hold = res8;
    @(posedge CLK); #1;
    drive(8, 1'b1, 32'h55, 32'h66, 1'b0);
    repeat (3) begin
      @(negedge CLK);
      check("bp_out_valid", 64'(ov8), 64'(1));
      check("bp_res_stable", 64'(res8), 64'(hold));
      check("bp_in_ready", 64'(r8), 64'(0));
      @(posedge CLK); #1;
    end
    drive(8, 1'b0, 0, 0, 1'b0);
    or8 = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    check("bp_ready_after_hs", 64'(r8), 64'(1));
    check("bp_valid_after_hs", 64'(ov8), 64'(0));

    // Asynchronous reset in the third CALC cycle.
    accept(8, 32'h7F, 32'hFF, 1'b0);
    repeat (3) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("arst_outputs", 64'({r8, ov8, bz8}), 64'(3'b100));
    check("arst_res", 64'(res8), 64'(0));
    @(posedge CLK); #1;
    RST = 1'b0;
    quiet(8, 14, "arst_no_output");

    // abort in CALC.
    accept(8, 32'h3C, 32'h5A, 1'b1);
    @(posedge CLK); #1;
    ab8 = 1'b1;
    @(posedge CLK); #1;
    ab8 = 1'b0;
    @(negedge CLK);
    check("abort_calc_idle", 64'({r8, bz8}), 64'(2'b10));
    quiet(8, 14, "abort_calc_no_output");

    // abort together with out_ready in DONE drops the product.
    or8 = 1'b0;
    accept(8, 32'h21, 32'h0B, 1'b0);
    wait_out(8, 9);
    @(posedge CLK); #1;
    ab8 = 1'b1;
    or8 = 1'b1;
    @(posedge CLK); #1;
    ab8 = 1'b0;
    @(negedge CLK);
    check("abort_done_idle", 64'({r8, ov8}), 64'(2'b10));

    op(8, 32'd7, 32'd6, 1'b0, 64'd42, 9);

    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a, b;
      logic s;
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      if (i % 50 == 0) a = 32'h8000_0000;
      if (i % 70 == 0) b = (i % 140 == 0) ? 32'h0 : 32'hFFFF_FFFF;
      if (i % 90 == 0) b = 32'h8000_0000;
      op(32, a, b, s, ref_mul(a, b, s, 32), 9);
    end

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", 64'(q4.size() + q8.size() + q32.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
